// File: rtl/dac_sample_scheduler.sv
// Paces a two-channel DAC driver: buffers one sample per channel and issues A/B pairs on each tick.
// Optional DAC_SCHED_IRQ_EN adds an irq output driven from the sticky status flags.
module dac_sample_scheduler #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 125,
    parameter int unsigned MIN_DIV     = 108
) (
`ifdef DAC_SCHED_IRQ_EN
    output logic                  irq,
`endif
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [1:0]            avsAdr,
    input  logic                  avsWr,
    input  logic [15:0]           avsWrData,
    input  logic                  avsRd,
    output logic [15:0]           avsRdData,
    input  logic                  snkValidA,
    input  logic [DATA_WIDTH-1:0] snkDataA,
    output logic                  snkRdyA,
    input  logic                  snkValidB,
    input  logic [DATA_WIDTH-1:0] snkDataB,
    output logic                  snkRdyB,
    output logic                  srcValid0,
    output logic [DATA_WIDTH-1:0] srcData0,
    input  logic                  srcRdy0,
    output logic                  srcValid1,
    output logic [DATA_WIDTH-1:0] srcData1,
    input  logic                  srcRdy1
);

`ifdef DAC_SCHED_IRQ_EN
    localparam int unsigned CtrlWidth = 4;
`else
    localparam int unsigned CtrlWidth = 2;
`endif

    typedef enum logic [1:0] {StIdle, StWaitTick, StIssue, StHold} state_e;

    state_e                  state_q;
    logic [CtrlWidth-1:0]    ctrl_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [DIV_WIDTH-1:0]    cnt_q;
    logic                    en_prev_q;
    logic                    underrun_q;
    logic                    late_q;
    logic [15:0]             ucnt_q;
    logic [15:0]             rd_data_q;
    logic                    sink_en_q;
    logic                    full_a_q, full_b_q;
    logic [DATA_WIDTH-1:0]   buf_a_q, buf_b_q;
    logic [DATA_WIDTH-1:0]   last_a_q, last_b_q;
    logic                    src_valid_q;
    logic [DATA_WIDTH-1:0]   src_a_q, src_b_q;

    logic enable, mode, tick, running;
    logic set_late, set_underrun, go_issue;
    logic acc_a, acc_b, consume_a, consume_b;
    logic wr_ctrl, wr_div, wr_status, wr_ucnt;
    logic [15:0] rd_mux;

    assign enable  = ctrl_q[0];
    assign mode    = ctrl_q[1];
    assign running = (state_q != StIdle);
    assign tick    = enable & en_prev_q & (cnt_q == '0);

    assign snkRdyA = sink_en_q & ~full_a_q;
    assign snkRdyB = sink_en_q & ~full_b_q;
    assign acc_a   = snkValidA & snkRdyA;
    assign acc_b   = snkValidB & snkRdyB;

    assign srcValid0 = src_valid_q;
    assign srcValid1 = src_valid_q;
    assign srcData0  = src_a_q;
    assign srcData1  = src_b_q;
    assign avsRdData = rd_data_q;

    assign wr_ctrl   = avsWr & (avsAdr == 2'd0);
    assign wr_div    = avsWr & (avsAdr == 2'd1);
    assign wr_status = avsWr & (avsAdr == 2'd2);
    assign wr_ucnt   = avsWr & (avsAdr == 2'd3);

    // Tick decision: a driver that is not ready takes precedence over an underrun.
    always_comb begin
        set_late     = 1'b0;
        set_underrun = 1'b0;
        go_issue     = 1'b0;
        if (state_q == StWaitTick && tick) begin
            if (!(srcRdy0 && srcRdy1)) begin
                set_late = 1'b1;
            end else if (full_a_q && full_b_q) begin
                go_issue = 1'b1;
            end else begin
                set_underrun = 1'b1;
                go_issue     = mode;
            end
        end
    end

    assign consume_a = go_issue & full_a_q;
    assign consume_b = go_issue & full_b_q;

    always_comb begin
        rd_mux = '0;
        unique case (avsAdr)
            2'd0: rd_mux = 16'(ctrl_q);
            2'd1: rd_mux = 16'(div_q);
            2'd2: rd_mux = {13'd0, late_q, underrun_q, running};
            2'd3: rd_mux = ucnt_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ctrl_q     <= '0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
            ucnt_q     <= '0;
            rd_data_q  <= '0;
            sink_en_q  <= 1'b0;
        end else begin
            sink_en_q <= 1'b1;
            if (wr_ctrl) ctrl_q <= avsWrData[CtrlWidth-1:0];
            if (wr_div) begin
                div_q <= (avsWrData < 16'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV)
                                                    : avsWrData[DIV_WIDTH-1:0];
            end
            // Set events win over a simultaneous write-one-to-clear.
            underrun_q <= set_underrun | (underrun_q & ~(wr_status & avsWrData[1]));
            late_q     <= set_late | (late_q & ~(wr_status & avsWrData[2]));
            if (wr_ucnt) begin
                ucnt_q <= set_underrun ? 16'd1 : 16'd0;
            end else if (set_underrun && ucnt_q != 16'hFFFF) begin
                ucnt_q <= ucnt_q + 16'd1;
            end
            if (avsRd) rd_data_q <= rd_mux;
        end
    end

`ifdef DAC_SCHED_IRQ_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) irq <= 1'b0;
        else         irq <= (underrun_q & ctrl_q[2]) | (late_q & ctrl_q[3]);
    end
`endif

    // Period counter: loads DIV-1 on the first enabled cycle, so the first tick lands DIV later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
        end else begin
            en_prev_q <= enable;
            if (!enable) begin
                cnt_q <= '0;
            end else if (!en_prev_q || cnt_q == '0) begin
                cnt_q <= div_q - DIV_WIDTH'(1);
            end else begin
                cnt_q <= cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            buf_a_q  <= '0;
            buf_b_q  <= '0;
        end else begin
            full_a_q <= (full_a_q & ~consume_a) | acc_a;
            full_b_q <= (full_b_q & ~consume_b) | acc_b;
            if (acc_a) buf_a_q <= snkDataA;
            if (acc_b) buf_b_q <= snkDataB;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            src_valid_q <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            last_a_q    <= '0;
            last_b_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    src_valid_q <= 1'b0;
                    if (enable) state_q <= StWaitTick;
                end
                StWaitTick: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (go_issue) begin
                        state_q     <= StIssue;
                        src_valid_q <= 1'b1;
                        src_a_q     <= full_a_q ? buf_a_q : last_a_q;
                        src_b_q     <= full_b_q ? buf_b_q : last_b_q;
                        last_a_q    <= full_a_q ? buf_a_q : last_a_q;
                        last_b_q    <= full_b_q ? buf_b_q : last_b_q;
                    end
                end
                StIssue: begin
                    src_valid_q <= 1'b0;
                    state_q     <= enable ? StHold : StIdle;
                end
                // The driver drops rdy one cycle late; this state masks that window.
                StHold: state_q <= enable ? StWaitTick : StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: producers push expected samples, a monitor pops them
// as pairs are issued; register behaviour is checked through the Avalon-MM port.
module tb_dac_sample_scheduler;

    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic [1:0]    avsAdr = '0;
    logic          avsWr = 1'b0;
    logic [15:0]   avsWrData = '0;
    logic          avsRd = 1'b0;
    logic [15:0]   avsRdData;
    logic          snkValidA = 1'b0, snkValidB = 1'b0;
    logic [DW-1:0] snkDataA = '0, snkDataB = '0;
    logic          snkRdyA, snkRdyB;
    logic          srcValid0, srcValid1;
    logic [DW-1:0] srcData0, srcData1;
    logic          srcRdy0 = 1'b0, srcRdy1 = 1'b0;
`ifdef DAC_SCHED_IRQ_EN
    logic          irq;
`endif

    dac_sample_scheduler dut (
`ifdef DAC_SCHED_IRQ_EN
        .irq       (irq),
`endif
        .clk       (clk),
        .resetN    (resetN),
        .avsAdr    (avsAdr),
        .avsWr     (avsWr),
        .avsWrData (avsWrData),
        .avsRd     (avsRd),
        .avsRdData (avsRdData),
        .snkValidA (snkValidA),
        .snkDataA  (snkDataA),
        .snkRdyA   (snkRdyA),
        .snkValidB (snkValidB),
        .snkDataB  (snkDataB),
        .snkRdyB   (snkRdyB),
        .srcValid0 (srcValid0),
        .srcData0  (srcData0),
        .srcRdy0   (srcRdy0),
        .srcValid1 (srcValid1),
        .srcData1  (srcData1),
        .srcRdy1   (srcRdy1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    logic [DW-1:0] qa[$], qb[$];
    logic [DW-1:0] model_last_a = '0, model_last_b = '0;
    logic [DW-1:0] next_a = 14'h0100, next_b = 14'h2000;
    bit            en_a = 1'b0, en_b = 1'b0;
    bit            hold0 = 1'b0;
    int            rdy_low = 110;
    int            rdy_cnt = 0;
    int            cyc = 0;
    int            pairs = 0;
    int            last_cyc = 0;
    int            period = 0;
    bit            prev_v = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = snkValidA && snkRdyA && resetN;
            @(posedge clk);
            #2;
            if (hs) begin
                qa.push_back(snkDataA);
                next_a = next_a + 14'd1;
            end
            snkValidA = en_a;
            snkDataA  = next_a;
        end
    end

    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = snkValidB && snkRdyB && resetN;
            @(posedge clk);
            #2;
            if (hs) begin
                qb.push_back(snkDataB);
                next_b = next_b + 14'd1;
            end
            snkValidB = en_b;
            snkDataB  = next_b;
        end
    end

    // Driver model: rdy drops for rdy_low cycles after each issued pair.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_cnt > 0) rdy_cnt--;
        srcRdy0 = (rdy_cnt == 0) && !hold0;
        srcRdy1 = (rdy_cnt == 0);
    end

    initial begin
        logic [DW-1:0] exp_a, exp_b;
        forever begin
            @(negedge clk);
            if (resetN && (srcValid0 || srcValid1)) begin
                check("pair_valid", {30'd0, srcValid0, srcValid1}, 32'd3);
                check("single_cycle", {31'd0, prev_v}, 32'd0);
                exp_a = (qa.size() > 0) ? qa.pop_front() : model_last_a;
                exp_b = (qb.size() > 0) ? qb.pop_front() : model_last_b;
                check("data_a", {18'd0, srcData0}, {18'd0, exp_a});
                check("data_b", {18'd0, srcData1}, {18'd0, exp_b});
                model_last_a = exp_a;
                model_last_b = exp_b;
                if (pairs > 0) period = cyc - last_cyc;
                last_cyc = cyc;
                pairs++;
                rdy_cnt = rdy_low;
            end
            prev_v = srcValid0 || srcValid1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_pairs(input int n, input int budget);
        int target;
        int i;
        target = pairs + n;
        i = 0;
        while (pairs < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("pair_timeout", {31'd0, pairs >= target}, 32'd1);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        avsAdr = a;
        avsWrData = d;
        avsWr = 1'b1;
        @(posedge clk);
        #1;
        avsWr = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        @(posedge clk);
        #1;
        avsAdr = a;
        avsRd = 1'b1;
        @(posedge clk);
        #1;
        avsRd = 1'b0;
        check(tag, {16'd0, avsRdData}, {16'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        // Reset state
        #12;
        check("rst_valid0", {31'd0, srcValid0}, 32'd0);
        check("rst_rdy_a", {31'd0, snkRdyA}, 32'd0);
        check("rst_rddata", {16'd0, avsRdData}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        wait_cycles(2);
        #1;
        check("rdy_a_after_rst", {31'd0, snkRdyA}, 32'd1);
        check("rdy_b_after_rst", {31'd0, snkRdyB}, 32'd1);
        expect_reg("ctrl_rst", 2'd0, 16'h0000);
        expect_reg("div_rst", 2'd1, 16'd125);
        expect_reg("status_rst", 2'd2, 16'h0000);
        expect_reg("ucnt_rst", 2'd3, 16'h0000);

        // Steady stream; buffers fill while disabled
        en_a = 1'b1;
        en_b = 1'b1;
        wait_cycles(5);
        reg_write(2'd0, 16'h0001);
        wait_pairs(4, 700);
        check("period_125", period, 32'd125);
        expect_reg("status_steady", 2'd2, 16'h0001);

        // Divider clamp
        rdy_low = 100;
        reg_write(2'd1, 16'd50);
        expect_reg("div_clamp", 2'd1, 16'd108);
        wait_pairs(3, 500);
        check("period_108", period, 32'd108);

        // Underrun mode 0: B stalled, A kept
        reg_write(2'd3, 16'h0000);
        en_b = 1'b0;
        wait_pairs(1, 200);
        pc = pairs;
        wait_cycles(364);
        check("u0_no_issue", pairs, pc);
        expect_reg("u0_ucnt", 2'd3, 16'd3);
        expect_reg("u0_status", 2'd2, 16'h0003);
        en_b = 1'b1;
        wait_pairs(1, 150);
        reg_write(2'd2, 16'h0002);
        expect_reg("u0_w1c", 2'd2, 16'h0001);

        // Underrun mode 1: A stalled after sending 0x1234
        en_a = 1'b0;
        wait_pairs(1, 150);
        next_a = 14'h1234;
        en_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!snkRdyA) break;
        end
        en_a = 1'b0;
        check("fill_a", {31'd0, snkRdyA}, 32'd0);
        reg_write(2'd3, 16'h0000);
        reg_write(2'd0, 16'h0003);
        wait_pairs(1, 150);
        check("last_a_model", {18'd0, model_last_a}, 32'h1234);
        wait_pairs(3, 400);
        expect_reg("u1_ucnt", 2'd3, 16'd3);
        reg_write(2'd0, 16'h0001);
        en_a = 1'b1;
        reg_write(2'd2, 16'h0002);
        wait_pairs(1, 150);

        // Late tick: channel 0 rdy held low across a tick
        hold0 = 1'b1;
        pc = pairs;
        wait_cycles(150);
        check("late_no_issue", pairs, pc);
        expect_reg("late_status", 2'd2, 16'h0005);
        hold0 = 1'b0;
        wait_pairs(1, 150);
        reg_write(2'd2, 16'h0004);
        expect_reg("late_w1c", 2'd2, 16'h0001);
        expect_reg("late_ucnt", 2'd3, 16'd3);

        // Disable during WAIT_TICK
        wait_cycles(20);
        reg_write(2'd0, 16'h0000);
        wait_cycles(2);
        expect_reg("dis_status", 2'd2, 16'h0000);
        pc = pairs;
        wait_cycles(300);
        check("dis_no_issue", pairs, pc);

        // Reset asserted during HOLD
        expect_reg("div_before_rst", 2'd1, 16'd108);
        reg_write(2'd0, 16'h0001);
        wait_pairs(1, 200);
        #1;
        resetN = 1'b0;
        #1;
        check("hold_rst_valid0", {31'd0, srcValid0}, 32'd0);
        check("hold_rst_valid1", {31'd0, srcValid1}, 32'd0);
        check("hold_rst_data0", {18'd0, srcData0}, 32'd0);
        check("hold_rst_rdy_b", {31'd0, snkRdyB}, 32'd0);
        check("hold_rst_rddata", {16'd0, avsRdData}, 32'd0);
        wait_cycles(3);
        @(negedge clk);
        qa.delete();
        qb.delete();
        model_last_a = '0;
        model_last_b = '0;
        resetN = 1'b1;
        expect_reg("ctrl_rst2", 2'd0, 16'h0000);
        expect_reg("div_rst2", 2'd1, 16'd125);
        expect_reg("status_rst2", 2'd2, 16'h0000);
        expect_reg("ucnt_rst2", 2'd3, 16'h0000);
        reg_write(2'd0, 16'h0001);
        wait_pairs(2, 400);
        check("period_after_rst", period, 32'd125);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
